// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module      : fetch_unit_if
// Description : Fetch-stage bundle: instruction memory, control-unit requests,
//               redirect sources, F/D buffer outputs and interrupt request.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 16
);
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              pc_enable;
  logic              f_d_buffer_enable;
  logic              flush;
  logic [1:0]        jump_sel;
  logic [PC_W-1:0]   jump_target;
  logic [PC_W-1:0]   ret_addr;
  logic              branch_taken;
  logic [PC_W-1:0]   branch_target;
  logic              interrupt;
  logic              int_ack;
  logic [INST_W-1:0] fd_inst;
  logic [PC_W-1:0]   fd_pc_next;
  logic [INST_W-1:0] fd_imm;
  logic              int_pending;

  // The fetch unit itself
  modport slave (
    output imem_addr, fd_inst, fd_pc_next, fd_imm, int_pending,
    input  imem_data, pc_enable, f_d_buffer_enable, flush, jump_sel,
           jump_target, ret_addr, branch_taken, branch_target,
           interrupt, int_ack
  );

  // Control unit, memory and the rest of the pipeline
  modport master (
    input  imem_addr, fd_inst, fd_pc_next, fd_imm, int_pending,
    output imem_data, pc_enable, f_d_buffer_enable, flush, jump_sel,
           jump_target, ret_addr, branch_taken, branch_target,
           interrupt, int_ack
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : PC register with prioritised redirect, F/D pipeline buffer with
//               one-cycle immediate squash, optional sticky interrupt latch
//               (enabled by macro FETCH_INT_LATCH_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int                PC_W       = 32,
  parameter int                INST_W     = 16,
  parameter logic [PC_W-1:0]   RESET_PC   = '0,
  parameter logic [PC_W-1:0]   INT_VECTOR = PC_W'(32'h0000_0001)
) (
  input  wire                  clk,
  input  wire                  rst_n,
  fetch_unit_if.slave          bus
);

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    SQUASH = 1'b1
  } state_t;

  state_t            r_state, w_state_next;
  logic [PC_W-1:0]   r_pc, w_pc_next, w_pc_plus1;
  logic [INST_W-1:0] r_fd_inst, w_fd_inst_next;
  logic [PC_W-1:0]   r_fd_pc_next, w_fd_pc_next_next;
  logic [INST_W-1:0] r_fd_imm, w_fd_imm_next;

  assign w_pc_plus1 = r_pc + PC_W'(1);

  // A resolved branch outranks anything the control unit asks for
  always_comb begin
    w_pc_next = r_pc;
    if (bus.branch_taken) begin
      w_pc_next = bus.branch_target;
    end else if (bus.pc_enable) begin
      case (bus.jump_sel)
        2'b00:   w_pc_next = w_pc_plus1;
        2'b01:   w_pc_next = bus.jump_target;
        2'b10:   w_pc_next = INT_VECTOR;
        default: w_pc_next = bus.ret_addr;
      endcase
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_fd_inst_next    = r_fd_inst;
    w_fd_pc_next_next = r_fd_pc_next;
    w_fd_imm_next     = r_fd_imm;
    if (bus.branch_taken) begin
      w_state_next      = NORMAL;
      w_fd_inst_next    = '0;
      w_fd_pc_next_next = '0;
    end else if (bus.f_d_buffer_enable) begin
      if (r_state == NORMAL && bus.flush) begin
        // Word behind the opcode is an immediate: keep it aside, issue a NOP
        w_state_next      = SQUASH;
        w_fd_imm_next     = bus.imem_data;
        w_fd_inst_next    = '0;
        w_fd_pc_next_next = '0;
      end else begin
        w_state_next      = NORMAL;
        w_fd_inst_next    = bus.imem_data;
        w_fd_pc_next_next = w_pc_plus1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_state      <= NORMAL;
      r_fd_inst    <= '0;
      r_fd_pc_next <= '0;
      r_fd_imm     <= '0;
    end else begin
      r_pc         <= w_pc_next;
      r_state      <= w_state_next;
      r_fd_inst    <= w_fd_inst_next;
      r_fd_pc_next <= w_fd_pc_next_next;
      r_fd_imm     <= w_fd_imm_next;
    end
  end

  assign bus.imem_addr  = r_pc;
  assign bus.fd_inst    = r_fd_inst;
  assign bus.fd_pc_next = r_fd_pc_next;
  assign bus.fd_imm     = r_fd_imm;

`ifdef FETCH_INT_LATCH_EN
  logic r_int_prev;
  logic r_int_latch;
  logic w_int_rise;

  assign w_int_rise = bus.interrupt & ~r_int_prev;

  // A new request wins over a same-cycle acknowledge so it is never lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_prev  <= 1'b0;
      r_int_latch <= 1'b0;
    end else begin
      r_int_prev <= bus.interrupt;
      if (w_int_rise) begin
        r_int_latch <= 1'b1;
      end else if (bus.int_ack) begin
        r_int_latch <= 1'b0;
      end
    end
  end

  assign bus.int_pending = r_int_latch;
`else
  logic unused_int_ack;

  assign unused_int_ack  = bus.int_ack;
  assign bus.int_pending = bus.interrupt;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, giving the program counter width in bits.
REQ-002 The block SHALL have parameter INST_W, default 16, giving the instruction word width in bits.
REQ-003 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-004 The block SHALL have parameter INT_VECTOR, default 32'h0000_0001, giving the PC loaded when jump_sel=10.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  reset, asynchronous and active-low.
REQ-007 imem_addr  out  PC_W  instruction memory address, equal to the current PC.
REQ-008 imem_data  in  INST_W  instruction word read combinationally from imem_addr.
REQ-009 pc_enable  in  1  from control unit; 1 advances the PC.
REQ-010 f_d_buffer_enable  in  1  from control unit; 1 loads the F/D buffer, 0 holds it.
REQ-011 flush  in  1  from control unit; squash the word fetched next.
REQ-012 jump_sel  in  2  from control unit: 00 PC+1, 01 jump_target, 10 INT_VECTOR, 11 ret_addr.
REQ-013 jump_target  in  PC_W  decode-stage jump/call target.
REQ-014 ret_addr  in  PC_W  return address reassembled from the memory stage.
REQ-015 branch_taken  in  1  execute-stage conditional branch resolved taken.
REQ-016 branch_target  in  PC_W  execute-stage branch destination.
REQ-017 interrupt  in  1  external interrupt request.
REQ-018 int_ack  in  1  control unit has entered its interrupt sequence.
REQ-019 fd_inst  out  INST_W  F/D buffered instruction; all-zero is NOP.
REQ-020 fd_pc_next  out  PC_W  F/D buffered PC+1 of fd_inst, used for CALL/interrupt pushes.
REQ-021 fd_imm  out  INST_W  F/D buffered immediate word, valid one cycle after an LDM flush.
REQ-022 int_pending  out  1  interrupt request presented to the control unit.

Function
REQ-023 Next-PC priority SHALL be: branch_taken selects branch_target unconditionally; otherwise, if pc_enable=1, jump_sel selects the source; otherwise the PC holds.
REQ-024 PC+1 SHALL wrap modulo 2^PC_W.
REQ-025 An FSM with states NORMAL and SQUASH SHALL control the F/D buffer.
REQ-026 In NORMAL, flush=1 with f_d_buffer_enable=1 SHALL capture imem_data into fd_imm, load fd_inst with 0 on the next edge, and move to SQUASH.
REQ-027 SQUASH SHALL last exactly one cycle, load the F/D buffer normally, and return to NORMAL.
REQ-028 branch_taken=1 SHALL load fd_inst=0 and fd_pc_next=0 on that edge regardless of f_d_buffer_enable, force NORMAL, and leave fd_imm unchanged.
REQ-029 f_d_buffer_enable=0 without branch_taken SHALL hold fd_inst, fd_pc_next, fd_imm and the FSM state; a flush arriving during a hold SHALL be ignored.
REQ-030 In a normal load, fd_inst SHALL take imem_data and fd_pc_next SHALL take PC+1, giving exactly 1-cycle fetch-to-decode latency.
REQ-031 A simultaneous jump_sel=01 and flush (JMP) SHALL redirect the PC and squash the sequential word in the same cycle.

Reset
REQ-032 While rst_n=0: PC=RESET_PC, fd_inst=0, fd_pc_next=0, fd_imm=0, FSM=NORMAL, interrupt latch=0, int_pending=0, all applied asynchronously.
REQ-033 Deassertion of rst_n mid-sequence SHALL resume fetch from RESET_PC with no held state.

Configuration
REQ-034 With macro FETCH_INT_LATCH_EN defined, a rising edge on interrupt SHALL set a sticky latch driving int_pending, cleared on the edge where int_ack=1; a request arriving in the same cycle as int_ack SHALL be kept pending.
REQ-035 Without FETCH_INT_LATCH_EN, int_pending SHALL equal interrupt combinationally and no latch SHALL exist.

Verification
REQ-036 Reset release, pc_enable=1, jump_sel=00, imem returns 16'h5C01,16'h5C02 -> fd_inst=5C01 then 5C02, fd_pc_next=1 then 2.
REQ-037 At PC=4, flush=1 (LDM), imem_data=16'h00AB -> next cycle fd_inst=0, fd_imm=00AB; the following cycle is a normal load.
REQ-038 branch_taken=1, branch_target=32'h40, with pc_enable=0 in the same cycle -> PC=40 and fd_inst=0 next cycle.
REQ-039 jump_sel=11, ret_addr=32'h1234, pc_enable=1 -> PC=1234; with pc_enable=0 the PC holds its value.
REQ-040 FETCH_INT_LATCH_EN defined, 1-cycle interrupt pulse -> int_pending stays 1 until the int_ack edge, then 0; rst_n=0 mid-pending clears it at once.
